// File: rtl/vote_debounce.sv
// Debounce filter for a registered majority-vote bit, with a one-deep transition event
// buffer (valid/ready), a saturating transition counter and a sticky overrun flag.
module vote_debounce #(
  parameter int unsigned STABLE_CYCLES = 4,
  parameter int unsigned CNT_W         = 8
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             z_in,
  output logic             filt_out,
  output logic             evt_valid,
  output logic             evt_rise,
  input  logic             evt_ready,
  output logic [CNT_W-1:0] edge_count,
  output logic             evt_overrun
);

  localparam logic [1:0] StStableLo = 2'd0;
  localparam logic [1:0] StChkHi    = 2'd1;
  localparam logic [1:0] StStableHi = 2'd2;
  localparam logic [1:0] StChkLo    = 2'd3;

  // run_q holds the differing samples already taken; the next one qualifies at LastRun.
  localparam logic [7:0] LastRun = 8'(STABLE_CYCLES - 1);

  logic [1:0]       state_q, state_d;
  logic [7:0]       run_q, run_d;
  logic             valid_q, valid_d;
  logic             rise_q, rise_d;
  logic             ovr_q, ovr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             raise;
  logic             accept;

  always_comb begin
    state_d = state_q;
    run_d   = run_q;
    raise   = 1'b0;
    unique case (state_q)
      StStableLo: begin
        if (z_in) begin
          state_d = StChkHi;
          run_d   = 8'd1;
        end
      end
      StChkHi: begin
        if (!z_in) begin
          state_d = StStableLo;
          run_d   = 8'd0;
        end else if (run_q >= LastRun) begin
          state_d = StStableHi;
          run_d   = 8'd0;
          raise   = 1'b1;
        end else begin
          run_d = run_q + 8'd1;
        end
      end
      StStableHi: begin
        if (!z_in) begin
          state_d = StChkLo;
          run_d   = 8'd1;
        end
      end
      StChkLo: begin
        if (z_in) begin
          state_d = StStableHi;
          run_d   = 8'd0;
        end else if (run_q >= LastRun) begin
          state_d = StStableLo;
          run_d   = 8'd0;
          raise   = 1'b1;
        end else begin
          run_d = run_q + 8'd1;
        end
      end
      default: begin
        state_d = StStableLo;
        run_d   = 8'd0;
      end
    endcase
  end

  assign accept = valid_q & evt_ready;

  always_comb begin
    valid_d = valid_q;
    rise_d  = rise_q;
    ovr_d   = ovr_q;
    cnt_d   = cnt_q;
    if (accept) begin
      valid_d = 1'b0;
    end
    if (raise) begin
      if (cnt_q != {CNT_W{1'b1}}) begin
        cnt_d = cnt_q + 1'b1;
      end
      // A slot freed by a same-edge accept takes the new event; otherwise it is dropped.
      if (!valid_q || accept) begin
        valid_d = 1'b1;
        rise_d  = (state_d == StStableHi);
      end else begin
        ovr_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= StStableLo;
      run_q   <= 8'd0;
      valid_q <= 1'b0;
      rise_q  <= 1'b0;
      ovr_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      run_q   <= run_d;
      valid_q <= valid_d;
      rise_q  <= rise_d;
      ovr_q   <= ovr_d;
      cnt_q   <= cnt_d;
    end
  end

  assign filt_out    = (state_q == StStableHi) || (state_q == StChkLo);
  assign evt_valid   = valid_q;
  assign evt_rise    = rise_q;
  assign evt_overrun = ovr_q;
  assign edge_count  = cnt_q;

endmodule

// File: tb/tb_vote_debounce.sv
// Scoreboarded bench for vote_debounce: accepted events are checked by a monitor against a
// queue of expected polarities; filter, counter and flag state are checked directly.
module tb_vote_debounce;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       z_in = 1'b0;
  logic       evt_ready = 1'b0;
  logic       filt_out, evt_valid, evt_rise, evt_overrun;
  logic [7:0] edge_count;

  logic       z2 = 1'b0;
  logic       ready2 = 1'b1;
  logic       filt2, valid2, rise2, ovr2;
  logic [1:0] cnt2;

  int checks = 0;
  int failures = 0;
  logic sb[$];
  logic mon_exp;

  always #5 clk = ~clk;

  vote_debounce #(.STABLE_CYCLES(4), .CNT_W(8)) dut (
    .clk         (clk),
    .resetn      (resetn),
    .z_in        (z_in),
    .filt_out    (filt_out),
    .evt_valid   (evt_valid),
    .evt_rise    (evt_rise),
    .evt_ready   (evt_ready),
    .edge_count  (edge_count),
    .evt_overrun (evt_overrun)
  );

  vote_debounce #(.STABLE_CYCLES(4), .CNT_W(2)) dut_sat (
    .clk         (clk),
    .resetn      (resetn),
    .z_in        (z2),
    .filt_out    (filt2),
    .evt_valid   (valid2),
    .evt_rise    (rise2),
    .evt_ready   (ready2),
    .edge_count  (cnt2),
    .evt_overrun (ovr2)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    z_in = 1'b0;
    evt_ready = 1'b0;
    z2 = 1'b0;
    sb.delete();
    tick(2);
    resetn = 1'b1;
  endtask

  // Inputs change at posedge+1, so the values seen here are what the next edge samples.
  always @(negedge clk) begin
    if (resetn && evt_valid && evt_ready) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL accept_unexpected actual=%0d expected=none", evt_rise);
      end else begin
        mon_exp = sb.pop_front();
        check("accept_rise", {31'd0, evt_rise}, {31'd0, mon_exp});
      end
    end
  end

  initial begin
    do_reset();
    check("rst_filt", {31'd0, filt_out}, 0);
    check("rst_valid", {31'd0, evt_valid}, 0);
    check("rst_count", {24'd0, edge_count}, 0);
    check("rst_ovr", {31'd0, evt_overrun}, 0);

    // Glitch: 3 high samples then low
    z_in = 1'b1;
    tick(3);
    check("glitch_filt_hi3", {31'd0, filt_out}, 0);
    z_in = 1'b0;
    tick(3);
    check("glitch_filt", {31'd0, filt_out}, 0);
    check("glitch_valid", {31'd0, evt_valid}, 0);
    check("glitch_count", {24'd0, edge_count}, 0);

    // Stable rise: qualifies on the 4th high sample
    z_in = 1'b1;
    tick(3);
    check("rise_filt_early", {31'd0, filt_out}, 0);
    tick(1);
    check("rise_filt", {31'd0, filt_out}, 1);
    check("rise_valid", {31'd0, evt_valid}, 1);
    check("rise_pol", {31'd0, evt_rise}, 1);
    check("rise_count", {24'd0, edge_count}, 1);
    tick(2);
    check("rise_hold_valid", {31'd0, evt_valid}, 1);
    sb.push_back(1'b1);
    evt_ready = 1'b1;
    tick(1);
    check("rise_accepted", {31'd0, evt_valid}, 0);
    tick(1);
    check("ready_idle", {31'd0, evt_valid}, 0);
    evt_ready = 1'b0;

    // Backpressure overrun
    do_reset();
    z_in = 1'b1;
    tick(4);
    z_in = 1'b0;
    tick(4);
    check("ovr_filt", {31'd0, filt_out}, 0);
    check("ovr_count", {24'd0, edge_count}, 2);
    check("ovr_pol_kept", {31'd0, evt_rise}, 1);
    check("ovr_flag", {31'd0, evt_overrun}, 1);
    check("ovr_valid", {31'd0, evt_valid}, 1);
    sb.push_back(1'b1);
    evt_ready = 1'b1;
    tick(1);
    evt_ready = 1'b0;
    check("ovr_drained", {31'd0, evt_valid}, 0);
    check("ovr_sticky", {31'd0, evt_overrun}, 1);

    // Accept and new event on the same edge
    do_reset();
    z_in = 1'b1;
    tick(4);
    z_in = 1'b0;
    tick(3);
    sb.push_back(1'b1);
    evt_ready = 1'b1;
    tick(1);
    check("sim_valid", {31'd0, evt_valid}, 1);
    check("sim_pol", {31'd0, evt_rise}, 0);
    check("sim_ovr", {31'd0, evt_overrun}, 0);
    check("sim_count", {24'd0, edge_count}, 2);
    sb.push_back(1'b0);
    tick(1);
    check("sim_drained", {31'd0, evt_valid}, 0);
    evt_ready = 1'b0;

    // Saturation with a 2-bit counter
    do_reset();
    for (int i = 0; i < 5; i++) begin
      z2 = ~z2;
      tick(4);
      check("sat_filt", {31'd0, filt2}, {31'd0, z2});
      check("sat_count", {30'd0, cnt2}, (i < 3) ? i + 1 : 3);
    end
    tick(4);
    check("sat_hold", {30'd0, cnt2}, 3);

    // Reset mid-check with an event pending
    do_reset();
    z_in = 1'b1;
    tick(4);
    z_in = 1'b0;
    tick(4);
    z_in = 1'b1;
    tick(3);
    resetn = 1'b0;
    #2;
    check("mrst_filt", {31'd0, filt_out}, 0);
    check("mrst_valid", {31'd0, evt_valid}, 0);
    check("mrst_pol", {31'd0, evt_rise}, 0);
    check("mrst_count", {24'd0, edge_count}, 0);
    check("mrst_ovr", {31'd0, evt_overrun}, 0);
    @(negedge clk);
    resetn = 1'b1;
    tick(3);
    check("mrst_filt_early", {31'd0, filt_out}, 0);
    tick(1);
    check("mrst_filt_rise", {31'd0, filt_out}, 1);
    check("mrst_count_after", {24'd0, edge_count}, 1);

    tick(2);
    check("sb_empty", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
